simplez_kbd_fifo: RTL and testbench

- Receive buffer between uart_rx and the Simplez keyboard registers (status 510, data 511).
- Replaces the single-byte rcv_flag/tecl_data capture, so bursts of keystrokes arriving while the CPU is busy are queued instead of overwritten.
- Presents a memory-mapped status byte and data byte to the CPU data-bus multiplexer.
- Pops exactly one byte per CPU read instruction, even though the address decode stays asserted for several cycles.

---
 rtl/simplez_kbd_fifo.sv | 52 +++++
 tb/tb_simplez_kbd_fifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/simplez_kbd_fifo.sv
// simplez_kbd_fifo: keyboard receive FIFO that pops one byte per rising edge of the CPU data select
module simplez_kbd_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rcv,
  input  logic [DW-1:0] rx_data,
  input  logic          data_sel,
  input  logic          status_sel,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   count
);
  localparam int DEPTH = 2 ** AW;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          data_sel_d, status_sel_d;
  logic          data_rd, status_rd, pop_ok, push_ok, drop;
  logic [DW-1:0] status_byte;
  assign empty       = count == '0;
  assign full        = count == (AW+1)'(DEPTH);
  assign data_rd     = data_sel & ~data_sel_d;
  assign status_rd   = status_sel & ~status_sel_d;
  assign pop_ok      = data_rd & ~empty;
  assign push_ok     = rcv & (~full | pop_ok);
  assign drop        = rcv & full & ~pop_ok;
  assign status_byte = {{(DW-3){1'b0}}, overflow, full, ~empty};
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= rx_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      dout         <= '0;
      data_sel_d   <= 1'b0;
      status_sel_d <= 1'b0;
    end else begin
      data_sel_d   <= data_sel;
      status_sel_d <= status_sel;
      rd_ptr       <= rd_ptr + AW'(pop_ok);
      wr_ptr       <= wr_ptr + AW'(push_ok);
      count        <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      overflow     <= drop ? 1'b1 : (status_rd & ~data_rd) ? 1'b0 : overflow;
      dout         <= data_rd ? (empty ? '0 : mem[rd_ptr]) : status_rd ? status_byte : dout;
    end
endmodule

// File: tb/tb_simplez_kbd_fifo.sv
// tb_simplez_kbd_fifo: scoreboard bench; stimulus queues expected dout, a monitor checks it after each access edge
module tb_simplez_kbd_fifo;
  logic       clk = 0, rstn = 0, rcv = 0, data_sel = 0, status_sel = 0;
  logic [7:0] rx_data = 0, dout;
  logic       empty, full, overflow;
  logic [4:0] count;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic       ds_q = 0, ss_q = 0;

  simplez_kbd_fifo #(.AW(4), .DW(8)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .rx_data(rx_data), .data_sel(data_sel),
    .status_sel(status_sel), .dout(dout), .empty(empty), .full(full),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  initial forever begin
    logic acc;
    @(posedge clk);
    acc = rstn && ((data_sel && !ds_q) || (status_sel && !ss_q));
    ds_q = rstn ? data_sel : 1'b0;
    ss_q = rstn ? status_sel : 1'b0;
    if (acc) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_access: unexpected access, dout=%02h", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout: got %02h expected %02h", dout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1 rcv = 1; rx_data = b;
    @(posedge clk); #1 rcv = 0;
  endtask

  task automatic rd_data(input logic [7:0] e, input int hold = 4);
    @(posedge clk); #1 data_sel = 1; exp_q.push_back(e);
    repeat (hold) @(posedge clk);
    #1 data_sel = 0;
    @(posedge clk); #1;
  endtask

  task automatic rd_status(input logic [7:0] e, input int hold = 2);
    @(posedge clk); #1 status_sel = 1; exp_q.push_back(e);
    repeat (hold) @(posedge clk);
    #1 status_sel = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    // reset state and a long status select counted once
    chk("reset_count", 8'(count), 8'd0);
    chk("reset_empty", 8'(empty), 8'd1);
    chk("reset_dout", dout, 8'h00);
    rd_status(8'h00, 3);
    chk("t1_count", 8'(count), 8'd0);
    chk("t1_empty", 8'(empty), 8'd1);
    // three bytes, held selects
    push(8'h41); repeat (10) @(posedge clk);
    push(8'h42); repeat (10) @(posedge clk);
    push(8'h43); #1;
    chk("t2_count", 8'(count), 8'd3);
    rd_status(8'h01);
    rd_data(8'h41); rd_data(8'h42); rd_data(8'h43);
    chk("t2_count_end", 8'(count), 8'd0);
    chk("t2_empty_end", 8'(empty), 8'd1);
    // overflow
    for (int i = 0; i <= 16; i++) push(8'(i));
    chk("t3_full", 8'(full), 8'd1);
    chk("t3_count", 8'(count), 8'd16);
    chk("t3_overflow", 8'(overflow), 8'd1);
    rd_status(8'h07);
    chk("t3_overflow_clr", 8'(overflow), 8'd0);
    for (int i = 0; i < 16; i++) rd_data(8'(i), 1);
    chk("t3_empty", 8'(empty), 8'd1);
    // push and pop together while full
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    @(posedge clk); #1 rcv = 1; rx_data = 8'hAA; data_sel = 1; exp_q.push_back(8'h20);
    @(posedge clk); #1 rcv = 0;
    @(posedge clk); #1 data_sel = 0;
    chk("t4_count", 8'(count), 8'd16);
    chk("t4_overflow", 8'(overflow), 8'd0);
    for (int i = 1; i < 16; i++) rd_data(8'(8'h20 + i), 2);
    rd_data(8'hAA, 2);
    chk("t4_empty", 8'(empty), 8'd1);
    // pop on empty with concurrent push
    @(posedge clk); #1 rcv = 1; rx_data = 8'h5A; data_sel = 1; exp_q.push_back(8'h00);
    @(posedge clk); #1 rcv = 0;
    @(posedge clk); #1 data_sel = 0;
    chk("t5_count", 8'(count), 8'd1);
    rd_data(8'h5A);
    // asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    rd_data(8'h60);
    @(posedge clk); #3 rstn = 0;
    #1;
    chk("t6_count", 8'(count), 8'd0);
    chk("t6_dout", dout, 8'h00);
    chk("t6_overflow", 8'(overflow), 8'd0);
    chk("t6_empty", 8'(empty), 8'd1);
    @(negedge clk); rstn = 1;
    rd_data(8'h00);
    repeat (3) @(posedge clk);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
